// File: rtl/bcd_to_bin_32.sv
// bcd_to_bin_32: iterative packed-BCD to unsigned binary converter.
// One digit per clock, most significant digit first: acc = acc*10 + digit.
module bcd_to_bin_32 #(
  parameter int DIGITS = 10,
  parameter int BIN_W  = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [4*DIGITS-1:0]   bcd_data_i,
  input  logic                  bcd_data_valid_i,
  output logic                  bcd_redy_o,
  output logic [BIN_W-1:0]      bin_data_o,
  output logic                  bin_data_valid_o,
  input  logic                  bin_redy_i,
  output logic                  bin_ovf_o,
  output logic                  bcd_err_o
);

  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int ACC_W = BIN_W + 4;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t              state;
  logic [4*DIGITS-1:0] sreg;
  logic [BIN_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic                ovf;
  logic                err;

  logic [3:0]          d;
  logic [ACC_W-1:0]    acc_x;
  logic [ACC_W-1:0]    tmp;
  logic [BIN_W-1:0]    acc_n;
  logic                ovf_n;
  logic                err_n;
  logic                last;

  always_comb begin
    d     = sreg[4*DIGITS-1 -: 4];
    acc_x = {4'b0, acc};
    tmp   = (acc_x << 3) + (acc_x << 1)
          + {{BIN_W{1'b0}}, d};
    err_n = err | (d > 4'd9);
    // once saturated, stay saturated
    ovf_n = ovf | (tmp[ACC_W-1:BIN_W] != 4'b0);
    acc_n = ovf_n ? '1 : tmp[BIN_W-1:0];
    last  = (cnt == CNT_W'(DIGITS - 1));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state            <= IDLE;
      sreg             <= '0;
      acc              <= '0;
      cnt              <= '0;
      ovf              <= 1'b0;
      err              <= 1'b0;
      bcd_redy_o       <= 1'b0;
      bin_data_o       <= '0;
      bin_data_valid_o <= 1'b0;
      bin_ovf_o        <= 1'b0;
      bcd_err_o        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bcd_redy_o && bcd_data_valid_i) begin
            sreg       <= bcd_data_i;
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            err        <= 1'b0;
            bcd_redy_o <= 1'b0;
            state      <= CONV;
          end else begin
            bcd_redy_o <= 1'b1;
          end
        end
        CONV: begin
          sreg <= sreg << 4;
          cnt  <= cnt + 1'b1;
          acc  <= acc_n;
          ovf  <= ovf_n;
          err  <= err_n;
          if (last) begin
            state            <= DONE;
            bin_data_valid_o <= 1'b1;
            bin_ovf_o        <= ovf_n & ~err_n;
            bcd_err_o        <= err_n;
            bin_data_o       <= err_n ? '0 : acc_n;
          end
        end
        DONE: begin
          if (bin_redy_i) begin
            bin_data_valid_o <= 1'b0;
            bcd_redy_o       <= 1'b1;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
